// File: rtl/ex_stage_pipe_if.sv
// ----------------------------------------------------------------------------
// ex_stage_pipe_if
// Bundles the ID/EX inputs, the MEM/WB forwarding taps, the pipeline control
// (stall_in/flush) and the EX/MEM outputs of the execute stage.
//   slave  : used by the execute stage (reads in_*, mem_*, wb_*, stall_in,
//            flush; drives ex_busy and out_*)
//   master : used by whatever drives the stage (pipeline glue or a bench)
// ----------------------------------------------------------------------------
interface ex_stage_pipe_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  // ID/EX boundary
  logic             in_valid;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [15:0]      in_imm;
  logic             in_alusrc;
  logic [REGW-1:0]  in_rs;
  logic [REGW-1:0]  in_rt;
  logic [REGW-1:0]  in_rd;
  logic             in_regwrite;
  logic             in_memtoreg;
  logic             in_memwrite;
  logic             in_branch;
  logic [1:0]       in_brcond;
  // forwarding taps
  logic [REGW-1:0]  mem_rd;
  logic             mem_regwrite;
  logic [WIDTH-1:0] mem_result;
  logic [REGW-1:0]  wb_rd;
  logic             wb_regwrite;
  logic [WIDTH-1:0] wb_result;
  // pipeline control
  logic             stall_in;
  logic             flush;
  logic             ex_busy;
  // EX/MEM boundary
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_store_data;
  logic [REGW-1:0]  out_rd;
  logic             out_regwrite;
  logic             out_memtoreg;
  logic             out_memwrite;
  logic             out_zero;
  logic             out_carry;
  logic             out_overflow;
  logic             out_set;
  logic             out_br_taken;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_imm, in_alusrc, in_rs, in_rt, in_rd,
           in_regwrite, in_memtoreg, in_memwrite, in_branch, in_brcond,
           mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result,
           stall_in, flush,
    output ex_busy, out_valid, out_result, out_store_data, out_rd,
           out_regwrite, out_memtoreg, out_memwrite, out_zero, out_carry,
           out_overflow, out_set, out_br_taken
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_imm, in_alusrc, in_rs, in_rt, in_rd,
           in_regwrite, in_memtoreg, in_memwrite, in_branch, in_brcond,
           mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result,
           stall_in, flush,
    input  ex_busy, out_valid, out_result, out_store_data, out_rd,
           out_regwrite, out_memtoreg, out_memwrite, out_zero, out_carry,
           out_overflow, out_set, out_br_taken
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// ----------------------------------------------------------------------------
// ex_stage_pipe
// Execute stage of the pipelined DLX core: operand forwarding from MEM/WB,
// immediate mux, ALU with flags, branch-condition evaluation, an iterative
// shift-add multiplier (one step per cycle) and the EX/MEM output register
// with hold (stall_in) and bubble (flush) behaviour.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : ex_stage_pipe_if.slave carrying ID/EX inputs, forwarding taps,
//           stall_in/flush, ex_busy and the registered EX/MEM outputs
// ----------------------------------------------------------------------------
module ex_stage_pipe #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_stage_pipe_if.slave  bus
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;
  localparam int MSB  = WIDTH - 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Contents of the EX/MEM register; an all-zero value is a bubble.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] store;
    logic [REGW-1:0]  rd;
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             set;
    logic             br_taken;
  } exout_t;

  // --------------------------------------------------------------------------
  // Operand forwarding (index 0 = rs, index 1 = rt). MEM beats WB; r0 never
  // forwards because it is hard-wired to zero in the register file.
  // --------------------------------------------------------------------------
  logic [REGW-1:0]  src_idx [2];
  logic [WIDTH-1:0] rf_val  [2];
  logic [WIDTH-1:0] fwd_val [2];

  assign src_idx[0] = bus.in_rs;
  assign src_idx[1] = bus.in_rt;
  assign rf_val[0]  = bus.in_a;
  assign rf_val[1]  = bus.in_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic mem_hit;
    logic wb_hit;
    assign mem_hit = bus.mem_regwrite && (bus.mem_rd == src_idx[gi]) &&
                     (src_idx[gi] != '0);
    assign wb_hit  = bus.wb_regwrite && (bus.wb_rd == src_idx[gi]) &&
                     (src_idx[gi] != '0);
    assign fwd_val[gi] = mem_hit ? bus.mem_result :
                         (wb_hit ? bus.wb_result : rf_val[gi]);
  end

  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_rt;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] opb;

  assign fwd_a  = fwd_val[0];
  assign fwd_rt = fwd_val[1];

  // Sign-extend (or truncate, for narrow datapaths) the 16-bit immediate.
  if (WIDTH > 16) begin : g_imm_wide
    assign imm_ext = {{(WIDTH-16){bus.in_imm[15]}}, bus.in_imm};
  end else if (WIDTH == 16) begin : g_imm_eq
    assign imm_ext = bus.in_imm;
  end else begin : g_imm_narrow
    assign imm_ext = bus.in_imm[WIDTH-1:0];
  end

  assign opb = bus.in_alusrc ? imm_ext : fwd_rt;

  // --------------------------------------------------------------------------
  // ALU. SUB carry is the borrow out of the unsigned subtraction.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_set;

  assign add_w = {1'b0, fwd_a} + {1'b0, opb};
  assign sub_w = {1'b0, fwd_a} - {1'b0, opb};
  assign shamt = opb[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_set = 1'b0;
    case (bus.in_op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        // same-sign operands producing a different-sign sum
        alu_v   = (fwd_a[MSB] == opb[MSB]) && (add_w[MSB] != fwd_a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (fwd_a[MSB] != opb[MSB]) && (sub_w[MSB] != fwd_a[MSB]);
      end
      OP_AND:   alu_res = fwd_a & opb;
      OP_OR:    alu_res = fwd_a | opb;
      OP_XOR:   alu_res = fwd_a ^ opb;
      OP_SLT: begin
        alu_set = $signed(fwd_a) < $signed(opb);
        alu_res = {{(WIDTH-1){1'b0}}, alu_set};
      end
      OP_SLTU: begin
        alu_set = fwd_a < opb;
        alu_res = {{(WIDTH-1){1'b0}}, alu_set};
      end
      OP_SLL:   alu_res = fwd_a << shamt;
      OP_SRL:   alu_res = fwd_a >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(fwd_a) >>> shamt);
      OP_PASSB: alu_res = opb;
      default:  alu_res = '0;  // MUL result comes from the iterative unit
    endcase
  end

  // --------------------------------------------------------------------------
  // Branch condition on the forwarded A operand, signed.
  // --------------------------------------------------------------------------
  logic a_is_zero;
  logic br_cond;

  assign a_is_zero = (fwd_a == '0);

  always_comb begin
    br_cond = 1'b0;
    case (bus.in_brcond)
      2'd0: br_cond = a_is_zero;
      2'd1: br_cond = !a_is_zero;
      2'd2: br_cond = !fwd_a[MSB] && !a_is_zero;
      2'd3: br_cond = fwd_a[MSB] || a_is_zero;
      default: br_cond = 1'b0;
    endcase
  end

  // Packet the current instruction would load into EX/MEM.
  exout_t alu_pkt;

  always_comb begin
    alu_pkt          = '0;
    alu_pkt.valid    = 1'b1;
    alu_pkt.result   = alu_res;
    alu_pkt.store    = fwd_rt;
    alu_pkt.rd       = bus.in_rd;
    alu_pkt.regwrite = bus.in_regwrite;
    alu_pkt.memtoreg = bus.in_memtoreg;
    alu_pkt.memwrite = bus.in_memwrite;
    alu_pkt.zero     = (alu_res == '0);
    alu_pkt.carry    = alu_c;
    alu_pkt.overflow = alu_v;
    alu_pkt.set      = alu_set;
    alu_pkt.br_taken = bus.in_branch && bus.in_valid && br_cond;
  end

  // --------------------------------------------------------------------------
  // Multiplier FSM + EX/MEM register
  // --------------------------------------------------------------------------
  state_t           state_q,  state_d;
  logic [CNTW-1:0]  cnt_q,    cnt_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  exout_t           cap_q,    cap_d;
  exout_t           out_q,    out_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cap_d    = cap_q;
    out_d    = out_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.stall_in) begin
          if (bus.in_valid && (bus.in_op == OP_MUL)) begin
            // Capture everything now: ID/EX and the forwarding taps move on
            // while the multiply runs.
            state_d  = S_BUSY;
            cnt_d    = '0;
            mcand_d  = fwd_a;
            mplier_d = opb;
            acc_d    = '0;
            cap_d    = alu_pkt;
            out_d    = '0;
          end else if (bus.in_valid) begin
            out_d = alu_pkt;
          end else begin
            out_d = '0;
          end
        end
      end
      S_BUSY: begin
        // Steps continue under stall; only the output register holds.
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
        if (!bus.stall_in) begin
          out_d = '0;
        end
      end
      S_DONE: begin
        if (!bus.stall_in) begin
          out_d        = cap_q;
          out_d.result = acc_q;
          out_d.zero   = (acc_q == '0);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush beats stall and aborts any multiply in flight.
    if (bus.flush) begin
      out_d   = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cap_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cap_q    <= cap_d;
      out_q    <= out_d;
    end
  end

  assign bus.ex_busy        = (state_q != S_IDLE);
  assign bus.out_valid      = out_q.valid;
  assign bus.out_result     = out_q.result;
  assign bus.out_store_data = out_q.store;
  assign bus.out_rd         = out_q.rd;
  assign bus.out_regwrite   = out_q.regwrite;
  assign bus.out_memtoreg   = out_q.memtoreg;
  assign bus.out_memwrite   = out_q.memwrite;
  assign bus.out_zero       = out_q.zero;
  assign bus.out_carry      = out_q.carry;
  assign bus.out_overflow   = out_q.overflow;
  assign bus.out_set        = out_q.set;
  assign bus.out_br_taken   = out_q.br_taken;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// ----------------------------------------------------------------------------
// tb_ex_stage_pipe
// Self-checking bench for ex_stage_pipe (WIDTH=32, REGW=5). A behavioural
// model computes expected EX/MEM contents from the instruction semantics and
// a compare process checks every cycle; directed vectors add literal checks.
// ----------------------------------------------------------------------------
module tb_ex_stage_pipe;
  localparam int WIDTH = 32;
  localparam int REGW  = 5;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_stage_pipe_if #(.WIDTH(WIDTH), .REGW(REGW)) bus ();

  ex_stage_pipe #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        regwrite, memtoreg, memwrite, zero, carry, ovf, set, br;
  } out_t;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
    if (src != 0 && bus.mem_regwrite && bus.mem_rd == src) return bus.mem_result;
    if (src != 0 && bus.wb_regwrite && bus.wb_rd == src) return bus.wb_result;
    return rf;
  endfunction

  function automatic out_t model_exec();
    out_t o;
    logic [31:0] a, rt, b;
    logic [32:0] wide;
    longint sa, sb, s;
    int sh;
    o  = '0;
    a  = fwd(bus.in_rs, bus.in_a);
    rt = fwd(bus.in_rt, bus.in_b);
    b  = bus.in_alusrc ? {{16{bus.in_imm[15]}}, bus.in_imm} : rt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (bus.in_op)
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        o.result = wide[31:0]; o.carry = wide[32];
        s = sa + sb; o.ovf = (s > MAXS) || (s < MINS);
      end
      4'd1: begin
        o.result = a - b; o.carry = (a < b);
        s = sa - sb; o.ovf = (s > MAXS) || (s < MINS);
      end
      4'd2: o.result = a & b;
      4'd3: o.result = a | b;
      4'd4: o.result = a ^ b;
      4'd5: begin o.result = (sa < sb) ? 32'd1 : 32'd0; o.set = o.result[0]; end
      4'd6: begin o.result = (a < b) ? 32'd1 : 32'd0; o.set = o.result[0]; end
      4'd7: o.result = a << sh;
      4'd8: o.result = a >> sh;
      4'd9: o.result = $unsigned($signed(a) >>> sh);
      4'd10: o.result = a * b;
      4'd11: o.result = b;
      default: o.result = 32'd0;
    endcase
    o.valid    = 1'b1;
    o.zero     = (o.result == 0);
    o.store    = rt;
    o.rd       = bus.in_rd;
    o.regwrite = bus.in_regwrite;
    o.memtoreg = bus.in_memtoreg;
    o.memwrite = bus.in_memwrite;
    case (bus.in_brcond)
      2'd0: o.br = (sa == 0);
      2'd1: o.br = (sa != 0);
      2'd2: o.br = (sa > 0);
      default: o.br = (sa <= 0);
    endcase
    o.br = o.br && bus.in_branch;
    return o;
  endfunction

  out_t exp_q = '0;
  out_t pend  = '0;
  bit   m_busy = 1'b0;
  int   m_steps = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q <= '0; m_busy <= 1'b0; m_steps <= 0;
    end else if (bus.flush) begin
      exp_q <= '0; m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_steps < WIDTH) begin
        m_steps <= m_steps + 1;
        if (!bus.stall_in) exp_q <= '0;
      end else if (!bus.stall_in) begin
        exp_q <= pend; m_busy <= 1'b0;
      end
    end else if (!bus.stall_in) begin
      if (!bus.in_valid) exp_q <= '0;
      else if (bus.in_op == 4'd10) begin
        pend <= model_exec(); m_busy <= 1'b1; m_steps <= 0; exp_q <= '0;
      end else exp_q <= model_exec();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_busy",    bus.ex_busy,        32'(m_busy));
      chk("out_valid",  bus.out_valid,      32'(exp_q.valid));
      chk("out_result", bus.out_result,     exp_q.result);
      chk("out_store",  bus.out_store_data, exp_q.store);
      chk("out_rd",     bus.out_rd,         32'(exp_q.rd));
      chk("out_regwr",  bus.out_regwrite,   32'(exp_q.regwrite));
      chk("out_m2r",    bus.out_memtoreg,   32'(exp_q.memtoreg));
      chk("out_memwr",  bus.out_memwrite,   32'(exp_q.memwrite));
      chk("out_zero",   bus.out_zero,       32'(exp_q.zero));
      chk("out_carry",  bus.out_carry,      32'(exp_q.carry));
      chk("out_ovf",    bus.out_overflow,   32'(exp_q.ovf));
      chk("out_set",    bus.out_set,        32'(exp_q.set));
      chk("out_br",     bus.out_br_taken,   32'(exp_q.br));
      if (bus.out_valid)
        $display("txn t=%0t rd=%0d result=%h store=%h z=%b c=%b v=%b s=%b br=%b",
                 $time, bus.out_rd, bus.out_result, bus.out_store_data, bus.out_zero,
                 bus.out_carry, bus.out_overflow, bus.out_set, bus.out_br_taken);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    bus.mem_rd = '0; bus.mem_regwrite = 1'b0; bus.mem_result = '0;
    bus.wb_rd  = '0; bus.wb_regwrite  = 1'b0; bus.wb_result  = '0;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    bus.in_imm = '0; bus.in_alusrc = 1'b0;
    bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_rd = 5'd7;
    bus.in_regwrite = 1'b1; bus.in_memtoreg = 1'b0; bus.in_memwrite = 1'b0;
    bus.in_branch = 1'b0; bus.in_brcond = 2'd0;
  endtask

  logic [3:0]  t_op  [8];
  logic [31:0] t_a   [8];
  logic [31:0] t_b   [8];
  logic [31:0] t_res [8];

  initial begin
    int n, vb;
    rst_n = 1'b0;
    set_instr(4'd0, 0, 0);
    bus.in_valid = 1'b0;
    no_fwd();
    bus.stall_in = 1'b0; bus.flush = 1'b0;
    repeat (2) step();
    chk_en = 1'b1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_busy", bus.ex_busy, 0);
    rst_n = 1'b1;

    set_instr(4'd0, 5, 7); step();
    chk("add_res", bus.out_result, 12); chk("add_valid", bus.out_valid, 1);
    chk("add_zero", bus.out_zero, 0);   chk("add_carry", bus.out_carry, 0);

    set_instr(4'd1, 32'h8000_0000, 1); step();
    chk("sub_res", bus.out_result, 32'h7FFF_FFFF); chk("sub_ovf", bus.out_overflow, 1);

    set_instr(4'd5, 32'hFFFF_FFFF, 1); step();
    chk("slt_res", bus.out_result, 1); chk("slt_set", bus.out_set, 1);

    set_instr(4'd0, 99, 1); bus.in_rs = 5'd3;
    bus.mem_rd = 5'd3; bus.mem_regwrite = 1'b1; bus.mem_result = 10;
    bus.wb_rd = 5'd3; bus.wb_regwrite = 1'b1; bus.wb_result = 20;
    step();
    chk("fwd_mem", bus.out_result, 11);

    set_instr(4'd0, 4, 1); bus.in_rs = 5'd0; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
    step();
    chk("fwd_r0", bus.out_result, 5);

    set_instr(4'd0, 1, 0); bus.in_rt = 5'd4; bus.in_memwrite = 1'b1;
    bus.mem_rd = 5'd5; bus.wb_rd = 5'd4;
    step();
    chk("fwd_wb_res", bus.out_result, 21); chk("fwd_wb_store", bus.out_store_data, 20);
    no_fwd();

    set_instr(4'd0, 10, 0); bus.in_alusrc = 1'b1; bus.in_imm = 16'hFFFE; step();
    chk("imm_res", bus.out_result, 8);

    set_instr(4'd9, 32'h8000_0000, 4); step();
    chk("sra_res", bus.out_result, 32'hF800_0000);
    set_instr(4'd7, 1, 33); step();
    chk("sll_res", bus.out_result, 2);

    t_op  = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd11, 4'd13, 4'd1};
    t_a   = '{32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd1, 32'h8000_0000, 32'd9, 32'd9, 32'd5};
    t_b   = '{32'hFF00, 32'hFF00, 32'hFF00, 32'hFFFF_FFFF, 32'd31, 32'h1234, 32'd9, 32'd5};
    t_res = '{32'hF000, 32'hFFF0, 32'h0FF0, 32'd1, 32'd1, 32'h1234, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      set_instr(t_op[i], t_a[i], t_b[i]); step();
      chk("tbl_res", bus.out_result, t_res[i]);
    end
    chk("sub0_zero", bus.out_zero, 1);

    set_instr(4'd0, 0, 0); bus.in_branch = 1'b1; bus.in_brcond = 2'd0; bus.in_regwrite = 1'b0;
    step(); chk("br_eqz", bus.out_br_taken, 1);
    set_instr(4'd0, 32'h8000_0000, 0); bus.in_branch = 1'b1; bus.in_brcond = 2'd2;
    step(); chk("br_gtz", bus.out_br_taken, 0);
    set_instr(4'd0, 0, 0); bus.in_branch = 1'b1; bus.in_brcond = 2'd3;
    step(); chk("br_lez", bus.out_br_taken, 1);

    // MUL 6*7 with a follow-on ADD held at the input
    set_instr(4'd10, 6, 7); step();
    set_instr(4'd0, 1, 1);
    n = 0; vb = 0;
    while (bus.ex_busy && n < 100) begin
      n++;
      if (bus.out_valid) vb++;
      step();
    end
    chk("mul_busy_cycles", 32'(n), 33);
    chk("mul_valid_while_busy", 32'(vb), 0);
    chk("mul_res", bus.out_result, 42); chk("mul_valid", bus.out_valid, 1);
    step();
    chk("post_mul_add", bus.out_result, 2);

    // stall holds an ALU result
    set_instr(4'd0, 2, 3); step();
    set_instr(4'd0, 100, 1); bus.stall_in = 1'b1;
    step(); step();
    chk("stall_hold_res", bus.out_result, 5); chk("stall_hold_valid", bus.out_valid, 1);
    bus.stall_in = 1'b0; step();
    chk("stall_release", bus.out_result, 101);

    // stall during DONE
    set_instr(4'd10, 3, 5); step();
    bus.in_valid = 1'b0;
    repeat (32) step();
    chk("done_busy", bus.ex_busy, 1);
    bus.stall_in = 1'b1;
    repeat (3) begin
      step();
      chk("done_stall_busy", bus.ex_busy, 1); chk("done_stall_valid", bus.out_valid, 0);
    end
    bus.stall_in = 1'b0; step();
    chk("done_res", bus.out_result, 15); chk("done_valid", bus.out_valid, 1);
    chk("done_busy_clr", bus.ex_busy, 0);

    // flush mid-BUSY
    set_instr(4'd10, 9, 9); step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    chk("flush_busy", bus.ex_busy, 0); chk("flush_valid", bus.out_valid, 0);
    step();
    chk("flush_busy2", bus.ex_busy, 0);

    // reset mid-MUL
    set_instr(4'd0, 1, 2); step();
    set_instr(4'd10, 9, 9); step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0; step();
    chk("rst2_valid", bus.out_valid, 0); chk("rst2_result", bus.out_result, 0);
    chk("rst2_store", bus.out_store_data, 0); chk("rst2_rd", bus.out_rd, 0);
    chk("rst2_busy", bus.ex_busy, 0);
    rst_n = 1'b1; step();
    set_instr(4'd0, 3, 4); step();
    chk("after_rst_add", bus.out_result, 7);

    bus.in_valid = 1'b0;
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised execute stage for the pipelined DLX core.
- Sits between the ID/EX and EX/MEM boundaries and contains:
  - operand forwarding from MEM and WB;
  - an immediate-select mux and ALU;
  - branch-condition evaluation;
  - an iterative multi-cycle multiplier with a busy handshake;
  - an EX/MEM output register that supports stall (hold) and flush (bubble).

Parameters:
WIDTH, 32, datapath width (power of two, >= 8)
REGW, 5, register-index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  ID/EX holds a real instruction
in_op  in  4  ALU op code
in_a  in  WIDTH  rs value from register file
in_b  in  WIDTH  rt value from register file
in_imm  in  16  immediate, sign-extended to WIDTH
in_alusrc  in  1  1 = operand B is in_imm
in_rs  in  REGW  source register A
in_rt  in  REGW  source register B
in_rd  in  REGW  destination register
in_regwrite  in  1  control, passed to MEM
in_memtoreg  in  1  control, passed to MEM
in_memwrite  in  1  control, passed to MEM
in_branch  in  1  instruction is a conditional branch
in_brcond  in  2  branch condition: 0 EQZ, 1 NEZ, 2 GTZ, 3 LEZ
mem_rd  in  REGW  destination in MEM stage
mem_regwrite  in  1  MEM stage writes mem_rd
mem_result  in  WIDTH  MEM-stage ALU result
wb_rd  in  REGW  destination in WB stage
wb_regwrite  in  1  WB stage writes wb_rd
wb_result  in  WIDTH  WB write data
stall_in  in  1  downstream hold
flush  in  1  kill the instruction entering the output register
ex_busy  out  1  multiplier occupied; upstream must hold ID/EX
out_valid  out  1  EX/MEM valid
out_result  out  WIDTH  registered result
out_store_data  out  WIDTH  registered forwarded rt value for stores
out_rd  out  REGW  registered destination register
out_regwrite  out  1  registered control
out_memtoreg  out  1  registered control
out_memwrite  out  1  registered control
out_zero  out  1  registered flag: result == 0
out_carry  out  1  registered carry flag
out_overflow  out  1  registered overflow flag
out_set  out  1  registered SLT bit
out_br_taken  out  1  registered: in_branch & in_valid & condition true

Behaviour:
- Reset (rst_n=0 at a rising edge): all outputs 0, multiplier FSM to IDLE, counter 0. Reset overrides stall_in and flush and aborts any multiply in progress.
- Forwarding is applied per operand, in priority order:
  - MEM hit: mem_regwrite & mem_rd==src & src!=0.
  - Else WB hit: wb_regwrite & wb_rd==src & src!=0.
  - Else the register-file value.
  - Register 0 is never forwarded.
- Operand B = in_alusrc ? sext(in_imm) : forwarded rt. out_store_data is always the forwarded rt.
- ALU ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLTU.
  - 7 SLL, 8 SRL, 9 SRA; shift amount = low log2(WIDTH) bits of B.
  - 10 MUL (low WIDTH bits of the product).
  - 11 PASSB.
  - 12-15 produce 0.
- Carry and overflow flags are meaningful for ADD/SUB only and are 0 for all other ops.
- Branch conditions use the forwarded A operand, signed: EQZ A==0, NEZ A!=0, GTZ A>0, LEZ A<=0.
- Accept rule: accept = in_valid & !ex_busy & !stall_in.
- Non-MUL op: latency 1. The result is registered on the accepting edge.
- Multiplier FSM:
  - IDLE -> BUSY when an accepted op==10. Forwarded operands and control are captured, the counter is cleared, and a bubble (out_valid=0) is loaded into the output register.
  - BUSY: one shift-add step per cycle. After WIDTH steps -> DONE.
  - DONE: if !stall_in, load the product with captured control (out_valid=1) and go to IDLE. Otherwise remain in DONE.
  - ex_busy = (state != IDLE).
  - MUL issued at edge t gives out_valid at edge t+WIDTH+1 when there is no stall.
- stall_in=1: the output register holds its value and no instruction is accepted. The multiplier still counts in BUSY but waits in DONE.
- flush=1 (wins over stall_in): on the next edge the output register becomes a bubble (out_valid, out_regwrite, out_memwrite, out_memtoreg and out_br_taken all 0) and the FSM returns to IDLE, aborting any multiply.
- in_valid=0: a bubble is loaded, unless stalled.

Test Plan:
- Reset, then ADD a=5, b=7 -> next cycle out_result=12, out_valid=1, out_zero=0, out_carry=0.
- SUB a=0x8000_0000, b=1 -> out_result=0x7FFF_FFFF, out_overflow=1. SLT a=-1, b=1 -> out_result=1, out_set=1.
- Forwarding: rs=3, mem_rd=3, mem_result=10, wb_rd=3, wb_result=20 -> MEM value wins. ADD b=1 -> 11. With rs=0 and mem_rd=0 -> no forwarding.
- MUL 6*7 with WIDTH=32:
  - ex_busy=1 for 33 cycles.
  - out_valid=0 while busy.
  - Then out_result=42 for one valid cycle.
  - The next instruction is accepted the cycle after ex_busy falls.
- Stall and flush:
  - stall_in held 3 cycles during DONE -> product is delivered only after release, and out_* hold their prior values while stalled.
  - flush asserted mid-BUSY -> out_valid=0, FSM returns to IDLE, ex_busy=0 next cycle.
- Branches: EQZ with A=0 -> out_br_taken=1. GTZ with A=0x8000_0000 -> 0. LEZ with A=0 -> 1. rst_n=0 asserted mid-MUL -> all outputs 0 on the next edge.
